// File: rtl/stopwatch_pkg.sv
// Shared constants and state encoding for the mm:ss.cc stopwatch.
package stopwatch_pkg;
  localparam int DIGIT_W = 4;
  localparam int DIGITS  = 6;
  localparam int DISP_W  = DIGIT_W * DIGITS;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX_UNITS = 4'd9;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX_TENS  = 4'd5;

  // 59:59.99 packed as {m10,m1,s10,s1,c10,c1}
  localparam logic [DISP_W-1:0] BCD_FULL_SCALE = 24'h595999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_SAT  = 2'd3
  } sw_state_t;
endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit counting 0..MAX; cy flags that this increment wraps the digit.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = DIGIT_MAX_UNITS
) (
  input  logic               clk_50mhz,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               cy
);
  logic [DIGIT_W-1:0] r_q;
  logic               w_at_max;

  assign w_at_max = (r_q == MAX);
  assign cy       = inc & w_at_max;
  assign q        = r_q;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc) begin
      r_q <= w_at_max ? '0 : r_q + 1'b1;
    end
  end
endmodule

// File: rtl/stopwatch_lap_core.sv
// Single-clock BCD stopwatch mm:ss.cc with a circular lap memory and recall browsing.
module stopwatch_lap_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 500000,
  parameter int LAP_DEPTH = 3,
  parameter int WRAP_MODE = 0,
  parameter int IDX_W     = 4
) (
  input  logic              clk_50mhz,
  input  logic              rst_n,
  input  logic              run_en,
  input  logic              clr,
  input  logic              lap_pulse,
  input  logic              recall_mode,
  input  logic              recall_next,
  output logic [DISP_W-1:0] disp_bcd,
  output logic [IDX_W-1:0]  lap_cnt,
  output logic [IDX_W-1:0]  lap_idx,
  output logic              lap_ovf,
  output logic              over,
  output logic              running,
  output sw_state_t         dbg_state
);
  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int PTR_W  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int SUM_W  = PTR_W + 2;
  localparam bit SAT_EN = (WRAP_MODE != 0);

  sw_state_t          r_state;
  sw_state_t          w_state_nxt;
  logic               r_running;
  logic               r_over;
  logic [PRE_W-1:0]   r_presc;
  logic               w_tick;
  logic               w_inc;
  logic               w_at_full;

  logic [DIGIT_W-1:0] w_c1, w_c10, w_s1, w_s10, w_m1, w_m10;
  logic               w_cy_c1, w_cy_c10, w_cy_s1, w_cy_s10, w_cy_m1, w_cy_m10;
  logic [DISP_W-1:0]  w_count;

  logic [DISP_W-1:0]  r_lap_mem [LAP_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [IDX_W-1:0]   r_lap_cnt;
  logic               r_lap_ovf;
  logic [IDX_W-1:0]   r_lap_idx;
  logic               r_rmode_d;
  logic               w_lap_wr;
  logic               w_full;
  logic [SUM_W-1:0]   w_rd_sum;
  logic [PTR_W-1:0]   w_rd_ptr;
  logic [DISP_W-1:0]  r_disp;

  // Prescaler: only advances in RUN, so pausing keeps the sub-tick phase.
  assign w_tick = (r_state == ST_RUN) && (r_presc == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (clr) begin
      r_presc <= '0;
    end else if (r_state == ST_RUN) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  assign w_count   = {w_m10, w_m1, w_s10, w_s1, w_c10, w_c1};
  assign w_at_full = (w_count == BCD_FULL_SCALE);
  assign w_inc     = w_tick & ~clr & ~(SAT_EN & w_at_full);

  bcd_digit_cnt #(.MAX(DIGIT_MAX_UNITS)) u_c1 (
    .clk_50mhz(clk_50mhz), .rst_n(rst_n), .clr(clr), .inc(w_inc),    .q(w_c1),  .cy(w_cy_c1));
  bcd_digit_cnt #(.MAX(DIGIT_MAX_UNITS)) u_c10 (
    .clk_50mhz(clk_50mhz), .rst_n(rst_n), .clr(clr), .inc(w_cy_c1),  .q(w_c10), .cy(w_cy_c10));
  bcd_digit_cnt #(.MAX(DIGIT_MAX_UNITS)) u_s1 (
    .clk_50mhz(clk_50mhz), .rst_n(rst_n), .clr(clr), .inc(w_cy_c10), .q(w_s1),  .cy(w_cy_s1));
  bcd_digit_cnt #(.MAX(DIGIT_MAX_TENS)) u_s10 (
    .clk_50mhz(clk_50mhz), .rst_n(rst_n), .clr(clr), .inc(w_cy_s1),  .q(w_s10), .cy(w_cy_s10));
  bcd_digit_cnt #(.MAX(DIGIT_MAX_UNITS)) u_m1 (
    .clk_50mhz(clk_50mhz), .rst_n(rst_n), .clr(clr), .inc(w_cy_s10), .q(w_m1),  .cy(w_cy_m1));
  bcd_digit_cnt #(.MAX(DIGIT_MAX_TENS)) u_m10 (
    .clk_50mhz(clk_50mhz), .rst_n(rst_n), .clr(clr), .inc(w_cy_m1),  .q(w_m10), .cy(w_cy_m10));

  // Saturation is checked before pause so a run that just hit full scale still locks.
  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (run_en) w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (SAT_EN && w_at_full) w_state_nxt = ST_SAT;
          else if (!run_en)        w_state_nxt = ST_HOLD;
        end
        ST_HOLD: if (run_en) w_state_nxt = ST_RUN;
        ST_SAT:  w_state_nxt = ST_SAT;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_over    <= !SAT_EN && w_cy_m10;
    end
  end

  // Lap capture stores the pre-tick value because the digits update on the same edge.
  assign w_lap_wr = lap_pulse & ~clr & ~recall_mode;
  assign w_full   = (r_lap_cnt == IDX_W'(LAP_DEPTH));

  always_ff @(posedge clk_50mhz) begin
    if (rst_n && w_lap_wr) begin
      r_lap_mem[r_wr_ptr] <= w_count;
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_lap_cnt <= '0;
      r_lap_ovf <= 1'b0;
    end else if (clr) begin
      r_wr_ptr  <= '0;
      r_lap_cnt <= '0;
      r_lap_ovf <= 1'b0;
    end else if (w_lap_wr) begin
      r_wr_ptr <= (r_wr_ptr == PTR_W'(LAP_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_full) r_lap_ovf <= 1'b1;
      else        r_lap_cnt <= r_lap_cnt + 1'b1;
    end
  end

  // Index is held at 0 outside recall and on the first recall cycle.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_rmode_d <= 1'b0;
      r_lap_idx <= '0;
    end else begin
      r_rmode_d <= recall_mode;
      if (clr || !recall_mode || !r_rmode_d) begin
        r_lap_idx <= '0;
      end else if (recall_next && (r_lap_cnt != '0)) begin
        r_lap_idx <= (r_lap_idx == r_lap_cnt - 1'b1) ? '0 : r_lap_idx + 1'b1;
      end
    end
  end

  // Newest lap sits at wr_ptr-1; lap_idx walks backwards from there.
  assign w_rd_sum = SUM_W'(r_wr_ptr) + SUM_W'(LAP_DEPTH - 1) - SUM_W'(r_lap_idx);
  assign w_rd_ptr = (w_rd_sum >= SUM_W'(LAP_DEPTH)) ? PTR_W'(w_rd_sum - SUM_W'(LAP_DEPTH))
                                                    : PTR_W'(w_rd_sum);

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_disp <= '0;
    end else if (!recall_mode) begin
      r_disp <= w_count;
    end else if (r_lap_cnt == '0) begin
      r_disp <= '0;
    end else begin
      r_disp <= r_lap_mem[w_rd_ptr];
    end
  end

  assign disp_bcd  = r_disp;
  assign lap_cnt   = r_lap_cnt;
  assign lap_idx   = r_lap_idx;
  assign lap_ovf   = r_lap_ovf;
  assign over      = r_over;
  assign running   = r_running;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Directed bench: wrap (dut0) and saturate (dut1) instances share stimulus, TICK_DIV=4, LAP_DEPTH=3.
module tb_stopwatch_lap_core;
  import stopwatch_pkg::*;

  logic clk, rst_n, run_en, clr, lap_pulse, recall_mode, recall_next;
  logic [23:0] disp0, disp1;
  logic [3:0]  cnt0, cnt1, idx0, idx1;
  logic        ovf0, ovf1, over0, over1, run0, run1;
  sw_state_t   st0, st1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        lap;
    logic        rmode;
    logic        rnext;
    logic [23:0] disp;
    logic [3:0]  cnt;
    logic [3:0]  idx;
    logic        ovf;
  } vec_t;

  vec_t tbl [12];

  stopwatch_lap_core #(.TICK_DIV(4), .LAP_DEPTH(3), .WRAP_MODE(0), .IDX_W(4)) dut0 (
    .clk_50mhz(clk), .rst_n(rst_n), .run_en(run_en), .clr(clr), .lap_pulse(lap_pulse),
    .recall_mode(recall_mode), .recall_next(recall_next), .disp_bcd(disp0), .lap_cnt(cnt0),
    .lap_idx(idx0), .lap_ovf(ovf0), .over(over0), .running(run0), .dbg_state(st0));

  stopwatch_lap_core #(.TICK_DIV(4), .LAP_DEPTH(3), .WRAP_MODE(1), .IDX_W(4)) dut1 (
    .clk_50mhz(clk), .rst_n(rst_n), .run_en(run_en), .clr(clr), .lap_pulse(lap_pulse),
    .recall_mode(recall_mode), .recall_next(recall_next), .disp_bcd(disp1), .lap_cnt(cnt1),
    .lap_idx(idx1), .lap_ovf(ovf1), .over(over1), .running(run1), .dbg_state(st1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic lap, input logic rmode, input logic rnext,
                              input logic [23:0] disp, input logic [3:0] cnt,
                              input logic [3:0] idx, input logic ovf);
    vec_t v;
    v.lap = lap; v.rmode = rmode; v.rnext = rnext;
    v.disp = disp; v.cnt = cnt; v.idx = idx; v.ovf = ovf;
    return v;
  endfunction

  task automatic pulse_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1);
  endtask

  initial begin
    // Recall browsing with laps .01..04 in a 3-slot memory (slot0 overwritten by .04).
    tbl[0]  = mk(0, 0, 0, 24'h000004, 4'd3, 4'd0, 1'b1);
    tbl[1]  = mk(0, 1, 0, 24'h000004, 4'd3, 4'd0, 1'b1);
    tbl[2]  = mk(0, 1, 1, 24'h000003, 4'd3, 4'd1, 1'b1);
    tbl[3]  = mk(0, 1, 1, 24'h000002, 4'd3, 4'd2, 1'b1);
    tbl[4]  = mk(0, 1, 1, 24'h000004, 4'd3, 4'd0, 1'b1);
    tbl[5]  = mk(0, 1, 1, 24'h000003, 4'd3, 4'd1, 1'b1);
    tbl[6]  = mk(0, 0, 1, 24'h000004, 4'd3, 4'd0, 1'b1);
    tbl[7]  = mk(0, 1, 0, 24'h000004, 4'd3, 4'd0, 1'b1);
    tbl[8]  = mk(1, 1, 0, 24'h000004, 4'd3, 4'd0, 1'b1);
    tbl[9]  = mk(0, 1, 1, 24'h000003, 4'd3, 4'd1, 1'b1);
    tbl[10] = mk(0, 0, 0, 24'h000004, 4'd3, 4'd0, 1'b1);
    tbl[11] = mk(0, 1, 1, 24'h000004, 4'd3, 4'd0, 1'b1);

    rst_n = 1'b0; run_en = 1'b0; clr = 1'b0; lap_pulse = 1'b0;
    recall_mode = 1'b0; recall_next = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    chk("reset_disp", disp0, 24'h0);
    chk("reset_cnt", 24'(cnt0), 24'd0);
    chk("reset_ovf_over_run", {21'd0, ovf0, over0, run0}, 24'd0);
    chk("reset_state", 24'(st0), 24'(ST_IDLE));

    // Ten ticks: first tick lands on the 5th edge after run_en, then every 4.
    run_en = 1'b1;
    step(42);
    chk("run10_disp", disp0, 24'h000010);
    chk("run10_running", 24'(run0), 24'd1);
    chk("run10_state", 24'(st0), 24'(ST_RUN));
    run_en = 1'b0;
    step(3);
    chk("hold_disp", disp0, 24'h000010);
    chk("hold_running", 24'(run0), 24'd0);
    chk("hold_state", 24'(st0), 24'(ST_HOLD));

    pulse_clr();
    chk("clr_disp", disp0, 24'h0);
    chk("clr_state", 24'(st0), 24'(ST_IDLE));

    // Laps sampled at edges 7/11/15/19 hold .01/.02/.03/.04; pause with the last one.
    for (int k = 1; k <= 19; k++) begin
      run_en = (k <= 18);
      lap_pulse = (k == 7 || k == 11 || k == 15 || k == 19);
      step(1);
    end
    lap_pulse = 1'b0;
    chk("laps_cnt", 24'(cnt0), 24'd3);
    chk("laps_ovf", 24'(ovf0), 24'd1);

    for (int i = 0; i < 12; i++) begin
      lap_pulse = tbl[i].lap;
      recall_mode = tbl[i].rmode;
      recall_next = tbl[i].rnext;
      step(1);
      lap_pulse = 1'b0;
      recall_next = 1'b0;
      step(1);
      chk($sformatf("tbl%0d_disp", i), disp0, tbl[i].disp);
      chk($sformatf("tbl%0d_cnt", i), 24'(cnt0), 24'(tbl[i].cnt));
      chk($sformatf("tbl%0d_idx", i), 24'(idx0), 24'(tbl[i].idx));
      chk($sformatf("tbl%0d_ovf", i), 24'(ovf0), 24'(tbl[i].ovf));
    end
    recall_mode = 1'b0;
    step(2);

    // Prescaler sits at 2 in HOLD: resume, tick falls on the 3rd edge together with clr and lap.
    for (int k = 1; k <= 3; k++) begin
      run_en = (k <= 2);
      clr = (k == 3);
      lap_pulse = (k == 3);
      step(1);
    end
    clr = 1'b0; lap_pulse = 1'b0;
    step(1);
    chk("clrmix_disp", disp0, 24'h0);
    chk("clrmix_cnt", 24'(cnt0), 24'd0);
    chk("clrmix_ovf", 24'(ovf0), 24'd0);
    chk("clrmix_state", 24'(st0), 24'(ST_IDLE));
    recall_mode = 1'b1;
    recall_next = 1'b1;
    step(1);
    recall_next = 1'b0;
    step(1);
    chk("clrmix_recall_disp", disp0, 24'h0);
    chk("clrmix_recall_idx", 24'(idx0), 24'd0);
    recall_mode = 1'b0;
    step(2);

    // Lap on the same edge as the tick to .08 keeps .07.
    for (int k = 1; k <= 33; k++) begin
      run_en = (k <= 32);
      lap_pulse = (k == 33);
      step(1);
    end
    lap_pulse = 1'b0;
    step(2);
    chk("ticklap_live", disp0, 24'h000008);
    chk("ticklap_cnt", 24'(cnt0), 24'd1);
    recall_mode = 1'b1;
    step(2);
    chk("ticklap_slot", disp0, 24'h000007);
    recall_mode = 1'b0;
    step(2);

    pulse_clr();
    force dut0.u_c1.r_q = 4'd8;  force dut1.u_c1.r_q = 4'd8;
    force dut0.u_c10.r_q = 4'd9; force dut1.u_c10.r_q = 4'd9;
    force dut0.u_s1.r_q = 4'd9;  force dut1.u_s1.r_q = 4'd9;
    force dut0.u_s10.r_q = 4'd5; force dut1.u_s10.r_q = 4'd5;
    force dut0.u_m1.r_q = 4'd9;  force dut1.u_m1.r_q = 4'd9;
    force dut0.u_m10.r_q = 4'd5; force dut1.u_m10.r_q = 4'd5;
    step(2);
    release dut0.u_c1.r_q;  release dut1.u_c1.r_q;
    release dut0.u_c10.r_q; release dut1.u_c10.r_q;
    release dut0.u_s1.r_q;  release dut1.u_s1.r_q;
    release dut0.u_s10.r_q; release dut1.u_s10.r_q;
    release dut0.u_m1.r_q;  release dut1.u_m1.r_q;
    release dut0.u_m10.r_q; release dut1.u_m10.r_q;
    step(1);
    chk("preload_disp0", disp0, 24'h595998);
    chk("preload_disp1", disp1, 24'h595998);

    // Ticks on edges 5 and 9 after run_en.
    for (int k = 1; k <= 10; k++) begin
      run_en = 1'b1;
      step(1);
      if (k == 6) begin
        chk("full_disp0", disp0, 24'h595999);
        chk("full_disp1", disp1, 24'h595999);
        chk("sat_state_k6", 24'(st1), 24'(ST_SAT));
        chk("wrap_running_k6", 24'(run0), 24'd1);
      end
      if (k == 8) chk("over_before", 24'(over0), 24'd0);
      if (k == 9) begin
        chk("over_pulse", 24'(over0), 24'd1);
        chk("over_pulse_disp", disp0, 24'h595999);
      end
      if (k == 10) begin
        chk("over_after", 24'(over0), 24'd0);
        chk("wrap_disp", disp0, 24'h000000);
        chk("sat_disp", disp1, 24'h595999);
        chk("sat_state", 24'(st1), 24'(ST_SAT));
        chk("sat_running", 24'(run1), 24'd0);
        chk("sat_over", 24'(over1), 24'd0);
      end
    end
    run_en = 1'b0;
    step(3);
    chk("sat_stays_state", 24'(st1), 24'(ST_SAT));
    chk("sat_stays_disp", disp1, 24'h595999);
    run_en = 1'b1;
    step(3);
    chk("sat_ignores_run", 24'(st1), 24'(ST_SAT));
    run_en = 1'b0;
    pulse_clr();
    chk("sat_clr_state", 24'(st1), 24'(ST_IDLE));
    chk("sat_clr_disp", disp1, 24'h0);

    // Build up state, then pull reset between clock edges.
    for (int k = 1; k <= 22; k++) begin
      run_en = 1'b1;
      lap_pulse = (k == 6 || k == 10 || k == 14 || k == 18);
      step(1);
    end
    lap_pulse = 1'b0;
    chk("prerst_disp", disp0, 24'h000005);
    chk("prerst_cnt", 24'(cnt1), 24'd3);
    chk("prerst_ovf", 24'(ovf1), 24'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_disp0", disp0, 24'h0);
    chk("arst_disp1", disp1, 24'h0);
    chk("arst_flags0", {12'd0, cnt0, idx0, ovf0, over0, run0, 1'b0}, 24'd0);
    chk("arst_flags1", {12'd0, cnt1, idx1, ovf1, over1, run1, 1'b0}, 24'd0);
    chk("arst_state1", 24'(st1), 24'(ST_IDLE));
    run_en = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(5);
    chk("postrst_state", 24'(st0), 24'(ST_IDLE));
    chk("postrst_disp", disp0, 24'h0);
    run_en = 1'b1;
    step(2);
    chk("postrst_run", 24'(run0), 24'd1);
    chk("postrst_run_state", 24'(st0), 24'(ST_RUN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
